pcmplay_barcolor_seq: RTL and testbench
=======================================

# pcmplay_barcolor_seq

Avalon-MM–programmable colour sequencer for the PCM player's level-bar display. It drives the 12-bit RGB444 bar-colour word consumed by the video overlay. A palette of four target colours is stepped through autonomously: a per-nibble fade toward each target, paced by the video frame tick, then a programmable hold. Software only configures it and optionally receives an end-of-sequence interrupt.

## Interface
- No parameters; palette depth fixed at 4, colour width fixed at 12 (R[11:8], G[7:4], B[3:0]).
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  3  Avalon-MM register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; writes take effect at the clk edge
- writedata  in  32  write data
- readdata  out  32  combinational read mux of `address`; unused bits read 0; no wait states
- frame_tick  in  1  one-clk pulse per video frame (vsync-derived, already synchronous to clk)
- out_port  out  12  current bar colour
- irq  out  1  level interrupt: done AND irq_en

## Operation
- Register map:
  - 0 CTRL (RW): bit0 run, bit1 loop, bit2 irq_en, bits5:4 last (index of final palette entry).
  - 1 STATUS: bit0 busy (R), bit1 done (R, W1C), bits5:4 idx (R), bits9:8 state (R: 0 IDLE, 1 FADE, 2 HOLD), bits27:16 current colour (R).
  - 2 DIV (RW): bits15:0; one step per DIV+1 frame_ticks.
  - 3 HOLD (RW): bits7:0; number of hold steps.
  - 4–7 PAL0–PAL3 (RW): bits11:0.
- Writing 1 to CTRL.run while IDLE: idx←0, prescaler←0, state←FADE. Writing run=1 while already running has no effect.
- Writing 0 to CTRL.run: state←IDLE on the next edge, idx is kept, out_port is frozen, done is unchanged.
- Prescaler: counts frame_ticks. When it reaches DIV on a frame_tick, it emits a one-clk step and clears. The comparison is `>=`, so lowering DIV mid-count takes effect immediately.
- FADE, on step:
  - if current == PAL[idx], go to HOLD and load hold_cnt←HOLD;
  - otherwise each nibble ≠ its target moves ±1 toward the target. Saturating, no wrap.
- HOLD, on step:
  - if hold_cnt ≠ 0, decrement;
  - otherwise advance:
    - idx < last: idx+1, go to FADE.
    - idx == last and loop: idx←0, go to FADE.
    - idx == last and not loop: go to IDLE, clear run, set done.
- IDLE: a write to STATUS bits27:16 (with bit1 written as 0) loads the current colour directly. This write is ignored while busy.
- Palette and HOLD writes during a run are used from the next comparison onward.
- Simultaneous hardware set of done and software W1C: set wins.
- Reset: out_port = 0x000, irq = 0, readdata mux outputs 0 for defined zero registers, all registers 0, state IDLE, idx 0, prescaler 0.

## Timing
- out_port is registered and changes one clk after the step pulse. The step pulse is itself one clk after the qualifying frame_tick, so colour latency from frame_tick is 2 clk.
- readdata is combinational, the same cycle as `address`. Register values reflect writes from the following cycle.
- Fade to a target of maximum nibble distance d takes d steps. Entering HOLD takes 1 further step. Hold lasts HOLD+1 steps. Per entry total: d + HOLD + 2 steps.
- done/irq assert one clk after the final step. irq deasserts one clk after the W1C write.

## Configuration
- Macro BARCOLOR_SEQ_IRQ_EN.
- Defined: CTRL.irq_en is implemented and irq = done & irq_en.
- Undefined: CTRL bit2 reads 0 and ignores writes. irq is tied 0. done still sets and clears as specified, for polling.

## Test plan
- Reset with clk running: out_port = 0x000, irq = 0, every address reads 0x00000000.
- Single entry:
  - Setup: DIV=0, HOLD=1, PAL0=0x0F0, CTRL=0x005, colour 0x000.
  - Green ramps 1…F over 15 frame_ticks. HOLD is entered on tick 16. done and irq assert after tick 18. run reads 0. out_port stays 0x0F0.
- Loop of two entries:
  - Setup: PAL0=0xF00, PAL1=0x00F, last=1, loop=1, DIV=1, HOLD=0.
  - The colour crosses between the entries via simultaneous R-down/B-up steps every 2 frame_ticks.
  - idx wraps 1→0. done never sets.
- Abort mid-fade:
  - Clear run at colour 0x070 while heading to 0x0F0.
  - Result: state IDLE, out_port holds 0x070. A further frame_tick causes no change.
- Race and DIV change:
  - W1C of done in the same cycle as the hardware set leaves done = 1.
  - Setting DIV from 10 to 2 while the prescaler is at 5 produces a step on the next frame_tick.
- Macro undefined: writing CTRL=0x004 reads back 0x000. A completed sequence sets done = 1 while irq stays 0.

Source files
------------

// File: rtl/pcmplay_barcolor_seq.sv
// Bar-colour sequencer: fades an RGB444 colour through a 4-entry palette, paced by frame_tick.
// Optional macro BARCOLOR_SEQ_IRQ_EN implements CTRL.irq_en and the irq output.
module pcmplay_barcolor_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        frame_tick,
  output logic [11:0] out_port,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FADE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state_r, state_nx_s;
  logic [1:0]  idx_r, idx_nx_s;
  logic [11:0] color_r, color_nx_s;
  logic [7:0]  hold_cnt_r, hold_cnt_nx_s;
  logic        done_r, done_nx_s;
  logic [15:0] presc_r, presc_nx_s;
  logic        step_r, step_nx_s;
  logic        irq_r;

  logic        loop_r;
  logic [1:0]  last_r;
  logic [15:0] div_r;
  logic [7:0]  hold_r;
  logic [11:0] pal_r [4];

  logic        wr_s, wr_ctrl_s, wr_status_s, busy_s;
  logic        irq_en_s, irq_en_nx_s;

  assign wr_s        = chipselect & ~write_n;
  assign wr_ctrl_s   = wr_s && (address == 3'd0);
  assign wr_status_s = wr_s && (address == 3'd1);
  assign busy_s      = (state_r != ST_IDLE);

`ifdef BARCOLOR_SEQ_IRQ_EN
  logic irq_en_r;

  // Interrupt enable bit of CTRL
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_r <= 1'b0;
    end else if (wr_ctrl_s) begin
      irq_en_r <= writedata[2];
    end else begin
      irq_en_r <= irq_en_r;
    end
  end

  assign irq_en_s    = irq_en_r;
  assign irq_en_nx_s = wr_ctrl_s ? writedata[2] : irq_en_r;
`else
  assign irq_en_s    = 1'b0;
  assign irq_en_nx_s = 1'b0;
`endif

  // One-step move of a nibble toward its target, saturating at the target
  function automatic logic [3:0] nib_step(input logic [3:0] cur, input logic [3:0] tgt);
    logic [3:0] res;
    if (cur < tgt) begin
      res = cur + 4'd1;
    end else if (cur > tgt) begin
      res = cur - 4'd1;
    end else begin
      res = cur;
    end
    return res;
  endfunction

  // Software-configured registers: CTRL loop/last, DIV, HOLD and palette
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loop_r <= 1'b0;
      last_r <= 2'd0;
      div_r  <= 16'd0;
      hold_r <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        pal_r[i] <= 12'd0;
      end
    end else if (wr_s) begin
      case (address)
        3'd0: begin
          loop_r <= writedata[1];
          last_r <= writedata[5:4];
        end
        3'd2:    div_r  <= writedata[15:0];
        3'd3:    hold_r <= writedata[7:0];
        3'd4, 3'd5, 3'd6, 3'd7: pal_r[address[1:0]] <= writedata[11:0];
        default: loop_r <= loop_r;
      endcase
    end else begin
      loop_r <= loop_r;
    end
  end

  // Next-state logic: prescaler, fade/hold sequencing, run control and done flag
  always_comb begin
    state_nx_s    = state_r;
    idx_nx_s      = idx_r;
    color_nx_s    = color_r;
    hold_cnt_nx_s = hold_cnt_r;
    done_nx_s     = done_r;
    presc_nx_s    = presc_r;
    step_nx_s     = 1'b0;
    if (wr_status_s && writedata[1]) begin
      done_nx_s = 1'b0;
    end else begin
      done_nx_s = done_r;
    end
    if (busy_s && frame_tick) begin
      if (presc_r >= div_r) begin
        presc_nx_s = 16'd0;
        step_nx_s  = 1'b1;
      end else begin
        presc_nx_s = presc_r + 16'd1;
        step_nx_s  = 1'b0;
      end
    end else begin
      presc_nx_s = presc_r;
      step_nx_s  = 1'b0;
    end
    if (busy_s && wr_ctrl_s && !writedata[0]) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (wr_ctrl_s && writedata[0]) begin
            state_nx_s = ST_FADE;
            idx_nx_s   = 2'd0;
            presc_nx_s = 16'd0;
            step_nx_s  = 1'b0;
          end else if (wr_status_s && !writedata[1]) begin
            color_nx_s = writedata[27:16];
          end else begin
            color_nx_s = color_r;
          end
        end
        ST_FADE: begin
          if (step_r) begin
            if (color_r == pal_r[idx_r]) begin
              state_nx_s    = ST_HOLD;
              hold_cnt_nx_s = hold_r;
            end else begin
              color_nx_s = {nib_step(color_r[11:8], pal_r[idx_r][11:8]),
                            nib_step(color_r[7:4],  pal_r[idx_r][7:4]),
                            nib_step(color_r[3:0],  pal_r[idx_r][3:0])};
            end
          end else begin
            state_nx_s = ST_FADE;
          end
        end
        ST_HOLD: begin
          if (step_r) begin
            if (hold_cnt_r != 8'd0) begin
              hold_cnt_nx_s = hold_cnt_r - 8'd1;
            end else if (idx_r < last_r) begin
              idx_nx_s   = idx_r + 2'd1;
              state_nx_s = ST_FADE;
            end else if (loop_r) begin
              idx_nx_s   = 2'd0;
              state_nx_s = ST_FADE;
            end else begin
              // hardware set overrides a same-cycle W1C
              state_nx_s = ST_IDLE;
              done_nx_s  = 1'b1;
            end
          end else begin
            state_nx_s = ST_HOLD;
          end
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= 2'd0;
      color_r    <= 12'd0;
      hold_cnt_r <= 8'd0;
      done_r     <= 1'b0;
      presc_r    <= 16'd0;
      step_r     <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      idx_r      <= idx_nx_s;
      color_r    <= color_nx_s;
      hold_cnt_r <= hold_cnt_nx_s;
      done_r     <= done_nx_s;
      presc_r    <= presc_nx_s;
      step_r     <= step_nx_s;
      irq_r      <= done_nx_s & irq_en_nx_s;
    end
  end

  // Register read mux; run reads back as the busy flag
  always_comb begin
    readdata = 32'd0;
    case (address)
      3'd0:    readdata = {26'd0, last_r, 1'b0, irq_en_s, loop_r, busy_s};
      3'd1:    readdata = {4'd0, color_r, 6'd0, state_r, 2'd0, idx_r, 2'd0, done_r, busy_s};
      3'd2:    readdata = {16'd0, div_r};
      3'd3:    readdata = {24'd0, hold_r};
      3'd4, 3'd5, 3'd6, 3'd7: readdata = {20'd0, pal_r[address[1:0]]};
      default: readdata = 32'd0;
    endcase
  end

  assign out_port = color_r;
  assign irq      = irq_r;

endmodule

// File: tb/tb_pcmplay_barcolor_seq.sv
// Self-checking bench for pcmplay_barcolor_seq: directed scenarios plus randomized palettes
// checked against a step-level reference model of the fade/hold sequence.
module tb_pcmplay_barcolor_seq;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [2:0]  address    = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'd0;
  logic [31:0] readdata;
  logic        frame_tick = 1'b0;
  logic [11:0] out_port;
  logic        irq;

`ifdef BARCOLOR_SEQ_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [11:0] m_pal [4];
  int          m_last, m_hold, m_div;
  bit          m_loop;
  logic [11:0] exp_col [$];
  int          exp_idx [$];
  logic [31:0] rd_v;
  logic [11:0] start_c;

  pcmplay_barcolor_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .frame_tick (frame_tick),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  function automatic logic [31:0] ctrl_word(input bit run, input bit loop, input bit ien, input int last);
    return 32'(run) | (32'(loop) << 1) | (32'(ien) << 2) | (32'(last) << 4);
  endfunction

  // colour one fade step closer to target, each channel independently
  function automatic logic [11:0] toward(input logic [11:0] c, input logic [11:0] t);
    int res = 0;
    for (int k = 0; k < 3; k++) begin
      int cn = int'((c >> (4 * k)) & 12'hF);
      int tn = int'((t >> (4 * k)) & 12'hF);
      if (cn < tn) cn = cn + 1;
      else if (cn > tn) cn = cn - 1;
      res = res + (cn << (4 * k));
    end
    return 12'(res);
  endfunction

  // Expected colour and idx after every step, from the palette walk rules
  task automatic gen_seq(input logic [11:0] start, input int max_steps);
    logic [11:0] c = start;
    int j = 0;
    bit fin = 1'b0;
    exp_col.delete(); exp_idx.delete();
    while (!fin && exp_col.size() < max_steps) begin
      while (c != m_pal[j]) begin
        c = toward(c, m_pal[j]);
        exp_col.push_back(c); exp_idx.push_back(j);
      end
      exp_col.push_back(c); exp_idx.push_back(j);
      for (int h = 0; h < m_hold; h++) begin
        exp_col.push_back(c); exp_idx.push_back(j);
      end
      if (j < m_last) j = j + 1;
      else if (m_loop) j = 0;
      else fin = 1'b1;
      exp_col.push_back(c); exp_idx.push_back(j);
    end
  endtask

  task automatic play_steps(input int nsteps, input string tag);
    for (int s = 0; s < nsteps; s++) begin
      for (int t = 0; t <= m_div; t++) begin
        tick();
        idle($urandom_range(1, 2));
      end
      rd(3'd1, rd_v);
      check_eq({tag, "_col"}, 32'(out_port), 32'(exp_col[s]));
      check_eq({tag, "_idx"}, 32'(rd_v[5:4]), 32'(exp_idx[s]));
    end
  endtask

  initial begin
    // reset with clock running
    idle(3);
    check_eq("rst_out", 32'(out_port), 32'h0);
    check_eq("rst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    idle(1);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), rd_v);
      check_eq($sformatf("rst_rd%0d", a), rd_v, 32'h0);
    end

    // single entry, with W1C racing the final step
    wr(3'd2, 32'd0); wr(3'd3, 32'd1); wr(3'd4, 32'h0F0);
    wr(3'd0, ctrl_word(1, 0, 1, 0));
    tick();
    check_eq("lat_before", 32'(out_port), 32'h000);
    idle(1);
    check_eq("ramp1", 32'(out_port), 32'h010);
    for (int i = 2; i <= 15; i++) begin
      tick(); idle(1);
      check_eq($sformatf("ramp%0d", i), 32'(out_port), 32'(i << 4));
    end
    tick(); idle(1);
    rd(3'd1, rd_v);
    check_eq("hold_state", 32'(rd_v[9:8]), 32'd2);
    check_eq("hold_col", 32'(rd_v[27:16]), 32'h0F0);
    tick(); idle(1);
    rd(3'd1, rd_v);
    check_eq("hold2_done", 32'(rd_v[1]), 32'd0);
    tick();
    wr(3'd1, 32'h2);
    rd(3'd1, rd_v);
    check_eq("race_done", 32'(rd_v[1]), 32'd1);
    check_eq("end_busy", 32'(rd_v[0]), 32'd0);
    check_eq("end_state", 32'(rd_v[9:8]), 32'd0);
    rd(3'd0, rd_v);
    check_eq("end_ctrl", rd_v, ctrl_word(0, 0, IRQ_ON, 0));
    check_eq("end_irq", 32'(irq), 32'(IRQ_ON));
    check_eq("end_out", 32'(out_port), 32'h0F0);
    wr(3'd1, 32'h2);
    rd(3'd1, rd_v);
    check_eq("w1c_done", 32'(rd_v[1]), 32'd0);
    check_eq("w1c_irq", 32'(irq), 32'd0);

    // CTRL bit2 readback depends on the build option
    wr(3'd0, 32'h4);
    rd(3'd0, rd_v);
    check_eq("ctrl_ien", rd_v, IRQ_ON ? 32'h4 : 32'h0);

    // abort mid-fade
    wr(3'd3, 32'd0); wr(3'd1, 32'h0);
    check_eq("load_col", 32'(out_port), 32'h000);
    wr(3'd0, ctrl_word(1, 0, 1, 0));
    for (int i = 0; i < 7; i++) begin
      tick(); idle(1);
    end
    check_eq("pre_abort", 32'(out_port), 32'h070);
    wr(3'd0, 32'h0);
    rd(3'd1, rd_v);
    check_eq("abort_state", 32'(rd_v[9:8]), 32'd0);
    tick(); idle(2);
    check_eq("abort_frozen", 32'(out_port), 32'h070);

    // lowering DIV mid-count; busy colour write ignored
    wr(3'd2, 32'd10);
    wr(3'd0, ctrl_word(1, 0, 1, 0));
    for (int i = 0; i < 5; i++) begin
      tick(); idle(1);
    end
    check_eq("div_wait", 32'(out_port), 32'h070);
    wr(3'd1, 32'h0ABC_0000);
    check_eq("busy_load", 32'(out_port), 32'h070);
    wr(3'd2, 32'd2);
    tick(); idle(1);
    check_eq("div_lower", 32'(out_port), 32'h080);
    wr(3'd0, 32'h0);

    // two-entry loop
    m_pal[0] = 12'hF00; m_pal[1] = 12'h00F; m_last = 1; m_hold = 0; m_div = 1; m_loop = 1'b1;
    wr(3'd4, 32'hF00); wr(3'd5, 32'h00F); wr(3'd2, 32'd1); wr(3'd3, 32'd0);
    wr(3'd1, 32'h0);
    gen_seq(12'h000, 80);
    wr(3'd0, ctrl_word(1, 1, 1, 1));
    play_steps(80, "loop");
    rd(3'd1, rd_v);
    check_eq("loop_nodone", 32'(rd_v[1]), 32'd0);
    check_eq("loop_noirq", 32'(irq), 32'd0);
    wr(3'd0, 32'h0);

    // randomized palettes, single pass
    for (int r = 0; r < 4; r++) begin
      m_div = $urandom_range(0, 2); m_hold = $urandom_range(0, 3);
      m_last = $urandom_range(0, 3); m_loop = 1'b0;
      for (int p = 0; p < 4; p++) begin
        m_pal[p] = 12'($urandom);
        wr(3'(4 + p), {20'd0, m_pal[p]});
      end
      wr(3'd2, 32'(m_div)); wr(3'd3, 32'(m_hold));
      start_c = 12'($urandom);
      wr(3'd1, {4'd0, start_c, 16'd0});
      gen_seq(start_c, 400);
      wr(3'd0, ctrl_word(1, 0, 1, m_last));
      play_steps(exp_col.size(), $sformatf("rand%0d", r));
      rd(3'd1, rd_v);
      check_eq("rand_done", 32'(rd_v[1]), 32'd1);
      check_eq("rand_busy", 32'(rd_v[0]), 32'd0);
      check_eq("rand_irq", 32'(irq), 32'(IRQ_ON));
      wr(3'd1, 32'h2);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
